// File: rtl/alu_req_driver.sv
// Request-side front end for the combinational ALU: queues valid/ready requests,
// drives the ALU from registers, and returns captured results in order.
module alu_req_driver #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_cmd,
  input  logic [N-1:0] req_op1,
  input  logic [N-1:0] req_op2,
  output logic [3:0]   alu_cmd,
  output logic [N-1:0] alu_op1,
  output logic [N-1:0] alu_op2,
  input  logic [N-1:0] alu_out,
  input  logic         alu_over,
  input  logic         alu_under,
  input  logic         alu_err,
  input  logic         alu_log,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic [3:0]   rsp_flags,
  output logic [3:0]   rsp_cmd,
  output logic         busy,
  output logic [7:0]   err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 4 + 2 * N;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  state_t        state_reg;
  logic          init_reg;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;

  // init_reg keeps req_ready low until the first edge after reset release
  assign req_ready = init_reg && (count_reg < CNT_FULL);
  assign busy      = (count_reg != '0) || (state_reg != IDLE);
  assign push      = req_valid && req_ready;
  assign pop       = (count_reg != '0) &&
                     ((state_reg == IDLE) || ((state_reg == HOLD) && rsp_ready));
  assign head      = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {req_cmd, req_op1, req_op2};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      state_reg  <= IDLE;
      init_reg   <= 1'b0;
      alu_cmd    <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_flags  <= '0;
      rsp_cmd    <= '0;
      err_count  <= '0;
    end else begin
      init_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: ;
      endcase

      case (state_reg)
        IDLE: begin
          if (pop) begin
            {alu_cmd, alu_op1, alu_op2} <= head;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data  <= alu_out;
          rsp_flags <= {alu_err, alu_log, alu_under, alu_over};
          rsp_cmd   <= alu_cmd;
          rsp_valid <= 1'b1;
          state_reg <= HOLD;
          if (alu_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (pop) begin
              {alu_cmd, alu_op1, alu_op2} <= head;
              state_reg <= ISSUE;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_driver.sv
// Bench for alu_req_driver: a behavioural ALU on the alu_* ports, a queue model of
// expected responses checked every cycle, and directed scenarios with literal checks.
module tb_alu_req_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_cmd = '0;
  logic [7:0] req_op1 = '0;
  logic [7:0] req_op2 = '0;
  logic [3:0] alu_cmd;
  logic [7:0] alu_op1, alu_op2, alu_out;
  logic       alu_over, alu_under, alu_err, alu_log;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags, rsp_cmd;
  logic       busy;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] cmd;
    logic [7:0] data;
    logic [3:0] flags;
  } rsp_t;

  rsp_t exp_q[$];
  int   m_err = 0;
  int   hs_count = 0;

  always #5 clk = ~clk;

  alu_req_driver #(.N(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
    .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_out(alu_out), .alu_over(alu_over), .alu_under(alu_under),
    .alu_err(alu_err), .alu_log(alu_log),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_cmd(rsp_cmd),
    .busy(busy), .err_count(err_count)
  );

  // Reference ALU; flags returned as {err, log, under, over}
  function automatic rsp_t alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    rsp_t r;
    logic [8:0]  s;
    logic [15:0] w;
    r.cmd = c; r.data = 8'd0; r.flags = 4'b0000;
    case (c)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r.data = s[7:0]; r.flags[0] = s[8]; end
      4'd1: begin r.data = a - b; r.flags[1] = (a < b); end
      4'd2: begin w = {8'd0, a} << b; r.data = w[7:0]; r.flags[0] = |w[15:8]; end
      4'd3: r.data = a >> b;
      4'd4: r.flags[2] = (a == b);
      4'd5: r.flags[2] = (a > b);
      4'd6: r.flags[2] = (a < b);
      default: r.flags[3] = 1'b1;
    endcase
    return r;
  endfunction

  rsp_t alu_r;
  assign alu_r = alu_f(alu_cmd, alu_op1, alu_op2);
  assign alu_out = alu_r.data;
  assign {alu_err, alu_log, alu_under, alu_over} = alu_r.flags;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: every accepted request owes one response, in order
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_err = 0;
    end else begin
      if (req_valid && req_ready) exp_q.push_back(alu_f(req_cmd, req_op1, req_op2));
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        if (exp_q[0].flags[3] && m_err < 255) m_err++;
        void'(exp_q.pop_front());
        hs_count++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", int'(busy), int'(exp_q.size() != 0));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          chk("rsp_cmd", int'(rsp_cmd), int'(exp_q[0].cmd));
          chk("rsp_data", int'(rsp_data), int'(exp_q[0].data));
          chk("rsp_flags", int'(rsp_flags), int'(exp_q[0].flags));
          chk("err_count_cap", int'(err_count),
              (m_err + int'(exp_q[0].flags[3]) > 255) ? 255 : m_err + int'(exp_q[0].flags[3]));
        end
      end else begin
        chk("err_count", int'(err_count), m_err);
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    req_valid = 1'b1; req_cmd = c; req_op1 = a; req_op2 = b;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("send_timeout", t, 0);
    @(negedge clk);
    req_valid = 1'b0;
    $display("req cmd=%0d op1=%0d op2=%0d accepted", c, a, b);
  endtask

  task automatic wait_rsp();
    int t = 0;
    while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("rsp_timeout", t, 0);
    $display("rsp cmd=%0d data=%0d flags=%b err_count=%0d", rsp_cmd, rsp_data, rsp_flags, err_count);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || rsp_valid) && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) chk("idle_timeout", t, 0);
  endtask

  initial begin
    int acc;
    int hs0;

    // Reset state
    #12;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_alu_cmd", int'(alu_cmd), 0);
    chk("rst_err_count", int'(err_count), 0);
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(req_ready), 1);

    // Single add, latency 2
    rsp_ready = 1'b1;
    send(4'd0, 8'd200, 8'd100);
    chk("lat_e0", int'(rsp_valid), 0);
    @(negedge clk);
    chk("lat_e1", int'(rsp_valid), 0);
    @(negedge clk);
    chk("lat_e2", int'(rsp_valid), 1);
    chk("add_data", int'(rsp_data), 44);
    chk("add_flags", int'(rsp_flags), 4'b0001);
    chk("add_cmd", int'(rsp_cmd), 0);
    $display("rsp cmd=%0d data=%0d flags=%b", rsp_cmd, rsp_data, rsp_flags);
    @(negedge clk);
    chk("add_done_valid", int'(rsp_valid), 0);

    // Sub then gt
    send(4'd1, 8'd5, 8'd9);
    wait_rsp();
    chk("sub_data", int'(rsp_data), 252);
    chk("sub_flags", int'(rsp_flags), 4'b0010);
    @(negedge clk);
    send(4'd5, 8'd9, 8'd5);
    wait_rsp();
    chk("gt_data", int'(rsp_data), 0);
    chk("gt_flags", int'(rsp_flags), 4'b0100);
    @(negedge clk);
    wait_idle();

    // Backpressure: 7 offers, DEPTH+1 accepted
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1;
      req_cmd = (acc % 2 == 0) ? 4'd0 : 4'd3;
      req_op1 = 8'(10 + acc * 37);
      req_op2 = 8'(acc);
      if (req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    $display("backpressure accepted=%0d", acc);
    chk("bp_accepted", acc, 5);
    chk("bp_ready_low", int'(req_ready), 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_back", int'(req_ready), 1);
    wait_idle();

    // Error path and saturation
    for (int i = 0; i < 3; i++) send(4'd9, 8'(i), 8'(i + 1));
    wait_idle();
    chk("err_count_3", int'(err_count), 3);
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'b1; req_cmd = 4'd9; req_op1 = 8'(i); req_op2 = 8'(i);
      while (!req_ready) @(negedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_idle();
    $display("err_count after 303 errors=%0d", err_count);
    chk("err_count_sat", int'(err_count), 255);

    // Push and pop on the same edge with two queued
    rsp_ready = 1'b0;
    hs0 = hs_count;
    send(4'd0, 8'd1, 8'd2);
    send(4'd0, 8'd3, 8'd4);
    send(4'd0, 8'd5, 8'd6);
    wait_rsp();
    req_valid = 1'b1; req_cmd = 4'd0; req_op1 = 8'd7; req_op2 = 8'd8;
    rsp_ready = 1'b1;
    chk("pp_ready", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pp_issue_valid", int'(rsp_valid), 0);
    chk("pp_ready_after", int'(req_ready), 1);
    wait_idle();
    chk("pp_responses", hs_count - hs0, 4);

    // Reset while holding with three queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd0, 8'(i), 8'd1);
    wait_rsp();
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(rsp_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(req_ready), 0);
    @(negedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(req_ready), 1);
    chk("post_rst_err", int'(err_count), 0);
    rsp_ready = 1'b1;
    send(4'd2, 8'd3, 8'd2);
    wait_rsp();
    chk("shl_data", int'(rsp_data), 12);
    chk("shl_cmd", int'(rsp_cmd), 2);
    @(negedge clk);
    wait_idle();
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
